// File: rtl/search_result_collector.sv
// Staggered engine launcher, round-robin hit capture and FWFT result FIFO.
// Optional SRC_COLLECT_STATS_EN adds hit_count and stall_seen outputs.
module search_result_collector #(
  parameter int NUM_CH     = 30,
  parameter int DATA_W     = 48,
  parameter int FIFO_DEPTH = 8,
  parameter int STAGGER    = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_n,
  input  logic [NUM_CH-1:0]        found,
  input  logic [NUM_CH*DATA_W-1:0] co_buf,
  output logic [NUM_CH-1:0]        ch_start,
  output logic [NUM_CH-1:0]        ext_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [DATA_W-1:0]        out_data,
  output logic [LVL_W-1:0]         fifo_level,
  output logic                     found_any
`ifdef SRC_COLLECT_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic                     stall_seen
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LAST  = (NUM_CH - 1) * STAGGER;
  localparam int CNT_W = $clog2(LAST + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      ch_start <= '0;
    end else begin
      s1 <= start_n;
      s2 <= s1;
      unique case (state)
        IDLE: if (!s2) begin
          ch_start[0] <= 1'b1;
          cnt         <= CNT_W'(1);
          state       <= (LAST == 0) ? DONE : RUN;
        end
        RUN: begin
          for (int i = 1; i < NUM_CH; i++)
            if (cnt == CNT_W'(i * STAGGER))
              ch_start[i] <= 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(LAST))
            state <= DONE;
        end
        default: ;
      endcase
    end
  end

  logic [NUM_CH-1:0] busy, released, req, rel, clr;
  logic [NUM_CH-1:0] gnt_oh;
  logic [CH_W-1:0]   ptr, gnt_ch;
  logic              gnt_v, space;
  logic [DATA_W-1:0] gnt_data;
  logic              cap_v;
  logic [CH_W-1:0]   cap_ch;
  logic [DATA_W-1:0] cap_data;
  logic [LVL_W-1:0]  level;

  assign req   = found & ch_start & ~busy;
  assign rel   = released | ext_res;
  assign clr   = busy & rel & ~found;
  // A capture already in flight owns a slot, so count it against capacity.
  assign space = (level + LVL_W'(cap_v)) < LVL_W'(FIFO_DEPTH);

  always_comb begin
    logic [CH_W:0] tmp;
    gnt_v    = 1'b0;
    gnt_ch   = '0;
    gnt_oh   = '0;
    gnt_data = '0;
    tmp      = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      tmp = {1'b0, ptr} + (CH_W+1)'(j);
      if (tmp >= (CH_W+1)'(NUM_CH))
        tmp = tmp - (CH_W+1)'(NUM_CH);
      if (!gnt_v && space && req[tmp[CH_W-1:0]]) begin
        gnt_v  = 1'b1;
        gnt_ch = tmp[CH_W-1:0];
      end
    end
    for (int i = 0; i < NUM_CH; i++)
      if (gnt_v && gnt_ch == CH_W'(i)) begin
        gnt_oh[i] = 1'b1;
        gnt_data  = co_buf[i*DATA_W +: DATA_W];
      end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      busy      <= '0;
      released  <= '0;
      cap_v     <= 1'b0;
      cap_ch    <= '0;
      cap_data  <= '0;
      ext_res   <= '0;
      found_any <= 1'b0;
    end else begin
      found_any <= |found;
      busy      <= (busy | gnt_oh) & ~clr;
      released  <= rel & busy & ~clr;
      cap_v     <= gnt_v;
      ext_res   <= '0;
      if (cap_v)
        for (int i = 0; i < NUM_CH; i++)
          if (cap_ch == CH_W'(i))
            ext_res[i] <= 1'b1;
      if (gnt_v) begin
        cap_ch   <= gnt_ch;
        cap_data <= gnt_data;
        ptr      <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
      end
    end
  end

  logic [CH_W+DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr, rd;
  logic                   pop;

  assign pop        = out_valid & out_ready;
  assign out_valid  = (level != '0);
  assign fifo_level = level;
  assign {out_ch, out_data} = mem[rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr    <= '0;
      rd    <= '0;
      level <= '0;
    end else begin
      if (cap_v) begin
        mem[wr] <= {cap_ch, cap_data};
        wr      <= wr + 1'b1;
      end
      if (pop)
        rd <= rd + 1'b1;
      level <= level + LVL_W'(cap_v) - LVL_W'(pop);
    end
  end

`ifdef SRC_COLLECT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      stall_seen <= 1'b0;
    end else begin
      if (cap_v && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 32'd1;
      if (|req && level == LVL_W'(FIFO_DEPTH))
        stall_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_search_result_collector.sv
// Scoreboard bench for search_result_collector: launch, capture order,
// backpressure and mid-run reset on a 6-channel, 4-deep configuration.
module tb_search_result_collector;

  localparam int NCH   = 6;
  localparam int DW    = 48;
  localparam int DEPTH = 4;
  localparam int STG   = 4;
  localparam int CW    = 3;
  localparam int LW    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_n;
  logic [NCH-1:0]    found;
  logic [NCH*DW-1:0] co_buf;
  logic [NCH-1:0]    ch_start;
  logic [NCH-1:0]    ext_res;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_ch;
  logic [DW-1:0]     out_data;
  logic [LW-1:0]     fifo_level;
  logic              found_any;
`ifdef SRC_COLLECT_STATS_EN
  logic [31:0]       hit_count;
  logic              stall_seen;
`endif

  search_result_collector #(
    .NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .STAGGER(STG)
  ) dut (
    .clk(clk), .rst(rst), .start_n(start_n),
    .found(found), .co_buf(co_buf),
    .ch_start(ch_start), .ext_res(ext_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data),
    .fifo_level(fifo_level), .found_any(found_any)
`ifdef SRC_COLLECT_STATS_EN
    , .hit_count(hit_count), .stall_seen(stall_seen)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [CW+DW-1:0] exp_q [$];
  logic [NCH-1:0]   ext_seen;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(int ph, int ch);
    return {8'(ph), 8'hC0, 32'(ch * 32'h0101_0101 + 32'h1234)};
  endfunction

  // Consumer at negedge, engine release model just after posedge.
  task automatic tick();
    logic [CW+DW-1:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      check("queue_nonempty", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pop_ch", 64'(out_ch), 64'(e[DW +: CW]));
        check("pop_data", 64'(out_data), 64'(e[DW-1:0]));
      end
    end
    @(posedge clk);
    #1;
    ext_seen = ext_seen | ext_res;
    for (int i = 0; i < NCH; i++)
      if (ext_res[i]) found[i] = 1'b0;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    found = '0;
    start_n = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_q.delete();
  endtask

  task automatic launch();
    start_n = 1'b0;
    repeat (3 + (NCH - 1) * STG) tick();
    start_n = 1'b1;
    tick();
    check("launch_all", 64'(ch_start), 64'({NCH{1'b1}}));
  endtask

  task automatic hit(int ph, int ch);
    co_buf[ch*DW +: DW] = mk(ph, ch);
    found[ch] = 1'b1;
    exp_q.push_back({CW'(ch), mk(ph, ch)});
  endtask

  initial begin
    logic [NCH-1:0] exp_s;
    int n;
    rst = 1'b1;
    start_n = 1'b1;
    found = '0;
    co_buf = '0;
    out_ready = 1'b0;
    ext_seen = '0;
    do_reset();

    check("rst_ch_start", 64'(ch_start), 0);
    check("rst_ext_res", 64'(ext_res), 0);
    check("rst_valid", 64'(out_valid), 0);
    check("rst_level", 64'(fifo_level), 0);
    check("rst_found_any", 64'(found_any), 0);
    check("rst_out_ch", 64'(out_ch), 0);
    check("rst_out_data", 64'(out_data), 0);

    start_n = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      for (int i = 0; i < NCH; i++)
        exp_s[i] = (k >= 3 + i * STG);
      check("launch_step", 64'(ch_start), 64'(exp_s));
    end
    start_n = 1'b1;
    repeat (3) tick();
    start_n = 1'b0;
    repeat (5) tick();
    check("second_press", 64'(ch_start), 64'({NCH{1'b1}}));
    start_n = 1'b1;

    ext_seen = '0;
    co_buf[2*DW +: DW] = 48'h0A0B0C0D0E0F;
    found[2] = 1'b1;
    exp_q.push_back({3'd2, 48'h0A0B0C0D0E0F});
    check("found_any_lag", 64'(found_any), 0);
    tick();
    check("single_valid_t", 64'(out_valid), 0);
    check("single_res_t", 64'(ext_res), 0);
    check("found_any", 64'(found_any), 1);
    tick();
    check("single_valid", 64'(out_valid), 1);
    check("single_ch", 64'(out_ch), 2);
    check("single_data", 64'(out_data), 48'h0A0B0C0D0E0F);
    check("single_res", 64'(ext_res), 64'(6'b000100));
    check("single_level", 64'(fifo_level), 1);
    tick();
    check("single_res_end", 64'(ext_res), 0);
    check("single_res_once", 64'(ext_seen), 64'(6'b000100));
    out_ready = 1'b1;
    drain(20);

    do_reset();
    launch();
    out_ready = 1'b1;
    hit(1, 0);
    hit(1, 1);
    hit(1, 3);
    drain(40);
    repeat (2) tick();
    check("fair_released", 64'(found), 0);
    hit(2, 0);
    hit(2, 3);
    drain(40);
    repeat (2) tick();
`ifdef SRC_COLLECT_STATS_EN
    check("hit_count5", 64'(hit_count), 5);
    check("stall_clear", 64'(stall_seen), 0);
`endif

    out_ready = 1'b0;
    ext_seen = '0;
    for (int i = 4; i < NCH; i++) hit(3, i);
    for (int i = 0; i < 4; i++) hit(3, i);
    repeat (10) tick();
    check("bp_level", 64'(fifo_level), DEPTH);
    check("bp_waiting", 64'(found), 64'(6'b001100));
    check("bp_released", 64'(ext_seen), 64'(6'b110011));
`ifdef SRC_COLLECT_STATS_EN
    check("stall_seen", 64'(stall_seen), 1);
`endif
    out_ready = 1'b1;
    drain(60);
    repeat (2) tick();
    check("bp_all_released", 64'(found), 0);
`ifdef SRC_COLLECT_STATS_EN
    check("hit_count11", 64'(hit_count), 11);
`endif

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) hit(4, i);
    n = 0;
    while (fifo_level != 3 && n < 20) begin
      tick();
      n++;
    end
    check("mid_level3", 64'(fifo_level), 3);
    rst = 1'b1;
    tick();
    check("mid_ch_start", 64'(ch_start), 0);
    check("mid_ext_res", 64'(ext_res), 0);
    check("mid_valid", 64'(out_valid), 0);
    check("mid_level", 64'(fifo_level), 0);
    check("mid_found_any", 64'(found_any), 0);
    check("mid_out_ch", 64'(out_ch), 0);
    check("mid_out_data", 64'(out_data), 0);
`ifdef SRC_COLLECT_STATS_EN
    check("mid_hit_count", 64'(hit_count), 0);
    check("mid_stall", 64'(stall_seen), 0);
`endif
    rst = 1'b0;
    ext_seen = '0;
    repeat (8) tick();
    check("post_no_res", 64'(ext_seen), 0);
    check("post_ch_start", 64'(ch_start), 0);
    check("post_level", 64'(fifo_level), 0);
    exp_q.delete();
    found = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
